// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter; ownership is held for the whole cyc envelope.
// Optional ack timeout with error pulse is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack,
  output logic [1:0]    gnt
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : gen_bad_timeout
    $error("wb_arbiter2: TIMEOUT out of range 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;  // index of the master that owned the bus most recently
  logic   own0, own1, owner_cyc, owner_stb, supp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? StOwn0 : StOwn1;
        else if (m0_cyc)      state_d = StOwn0;
        else if (m1_cyc)      state_d = StOwn1;
      end
      StOwn0: begin
        if (!m0_cyc) begin
          last_d  = 1'b0;
          state_d = m1_cyc ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (!m1_cyc) begin
          last_d  = 1'b1;
          state_d = m0_cyc ? StOwn0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign own0      = (state_q == StOwn0);
  assign own1      = (state_q == StOwn1);
  assign owner_cyc = (own0 & m0_cyc) | (own1 & m1_cyc);
  assign owner_stb = (own0 & m0_stb) | (own1 & m1_stb);

  assign gnt      = {own1, own0};
  assign s_cyc    = owner_cyc;
  assign s_stb    = owner_stb & ~supp;
  assign s_we     = own1 ? m1_we    : m0_we;
  assign s_adr    = own1 ? m1_adr   : m0_adr;
  assign s_dat_o  = own1 ? m1_dat_i : m0_dat_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack   = own0 & s_ack & ~supp;
  assign m1_ack   = own1 & s_ack & ~supp;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        supp_q, supp_d;
  logic        waiting, tmo;

  assign waiting = s_cyc & s_stb & ~s_ack;
  assign tmo     = waiting & (cnt_q == TmoLast);
  assign supp    = supp_q;
  assign m0_err  = own0 & tmo;
  assign m1_err  = own1 & tmo;

  // Leaving ownership always passes through owner cyc low, which clears both.
  always_comb begin
    cnt_d  = (waiting && !tmo) ? cnt_q + 16'd1 : 16'd0;
    supp_d = supp_q;
    if (tmo)             supp_d = 1'b1;
    else if (!owner_cyc) supp_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 16'd0;
      supp_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      supp_q <= supp_d;
    end
  end
`else
  assign supp   = 1'b0;
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized traffic
// against a transaction-level ownership model.
module tb_wb_arbiter2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [15:0] m0_adr, m0_dat_i, m1_adr, m1_dat_i;
  logic [15:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [15:0] s_adr, s_dat_o, s_dat_i;
  logic [1:0]  gnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .gnt(gnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    m0_adr = '0; m0_dat_i = '0; m1_adr = '0; m1_dat_i = '0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    step();
    step();
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: gnt=%b s_cyc=%b s_stb=%b, need 00 0 0", gnt, s_cyc, s_stb);
    end
    checks++;
    if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ack_err: got %b, need 0000", {m0_ack, m1_ack, m0_err, m1_err});
    end
    clear_inputs();
    rst_n = 1'b1;
    step();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'h4010;
    #1;
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL first_grant_latency: gnt=%b s_cyc=%b, need 00 0", gnt, s_cyc);
    end
    step();
    checks++;
    if (gnt !== 2'b10 || s_adr !== 16'h4010 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%b s_adr=%h s_cyc=%b, need 10 4010 1", gnt, s_adr, s_cyc);
    end
  endtask

  task automatic test_tie_handoff();
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL tie_grant: gnt=%b, need 01", gnt);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    checks++;
    if (gnt !== 2'b10 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL handoff: gnt=%b s_cyc=%b, need 10 1", gnt, s_cyc);
    end
    clear_inputs();
    step();
    checks++;
    if (gnt !== 2'b00) begin
      errors++;
      $display("FAIL release_idle: gnt=%b, need 00", gnt);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] want;
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      m0_stb = want[0]; m1_stb = want[1]; s_ack = 1'b1;
      #1;
      checks++;
      if (gnt !== want || {m1_ack, m0_ack} !== want) begin
        errors++;
        $display("FAIL fairness_%0d: gnt=%b acks=%b, need %b", i, gnt, {m1_ack, m0_ack}, want);
      end
      step();
      // owner releases after its single transaction
      s_ack = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
      if (want[0]) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_ack_routing();
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 16'h5000;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'h7777;
    step();
    checks++;
    if (gnt !== 2'b01 || s_adr !== 16'h5000 || s_we !== 1'b0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: gnt=%b s_adr=%h s_we=%b m0_ack=%b, need 01 5000 0 0",
               gnt, s_adr, s_we, m0_ack);
    end
    s_dat_i = 16'hBEEF; s_ack = 1'b1;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m0_dat_o !== 16'hBEEF || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_route: m0_ack=%b m0_dat_o=%h m1_ack=%b, need 1 beef 0",
               m0_ack, m0_dat_o, m1_ack);
    end
    clear_inputs();
    step();
    step();
    s_ack = 1'b1;
    #1;
    checks++;
    if (gnt !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_drop: gnt=%b m0_ack=%b m1_ack=%b, need 00 0 0", gnt, m0_ack, m1_ack);
    end
    s_ack = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'h1234;
    step();
    for (int t = 0; t < 3; t++) begin
      m0_stb = 1'b1; m0_adr = 16'(16'h0100 + t); s_ack = 1'b1;
      #1;
      checks++;
      if (gnt !== 2'b01 || m1_ack !== 1'b0 || m0_ack !== 1'b1 || s_adr !== 16'(16'h0100 + t)) begin
        errors++;
        $display("FAIL lock_%0d: gnt=%b m0_ack=%b m1_ack=%b s_adr=%h, need 01 1 0 %h",
                 t, gnt, m0_ack, m1_ack, s_adr, 16'(16'h0100 + t));
      end
      step();
      m0_stb = 1'b0; s_ack = 1'b0;
      step();
    end
    m0_cyc = 1'b0;
    step();
    checks++;
    if (gnt !== 2'b10 || s_adr !== 16'h1234) begin
      errors++;
      $display("FAIL lock_release: gnt=%b s_adr=%h, need 10 1234", gnt, s_adr);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (m1_err !== (k == 8) || s_stb !== 1'b1 || m0_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_cycle_%0d: m1_err=%b s_stb=%b m0_err=%b, need %b 1 0",
                 k, m1_err, s_stb, m0_err, (k == 8));
      end
      step();
    end
    s_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (s_stb !== 1'b0 || m1_err !== 1'b0 || m1_ack !== 1'b0 || gnt !== 2'b10) begin
        errors++;
        $display("FAIL timeout_suppress_%0d: s_stb=%b m1_err=%b m1_ack=%b gnt=%b, need 0 0 0 10",
                 k, s_stb, m1_err, m1_ack, gnt);
      end
      step();
    end
    s_ack = 1'b0;
`else
    for (int k = 1; k <= 20; k++) begin
      checks++;
      if (m1_err !== 1'b0 || s_stb !== 1'b1) begin
        errors++;
        $display("FAIL no_timeout_%0d: m1_err=%b s_stb=%b, need 0 1", k, m1_err, s_stb);
      end
      step();
    end
`endif
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: gnt=%b s_cyc=%b, need 00 0", gnt, s_cyc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: gnt=%b s_cyc=%b m0_ack=%b, need 00 0 0", gnt, s_cyc, m0_ack);
    end
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  // Model: owner is -1 (nobody) or the master index; last is who was served most recently.
  task automatic test_random();
    int          owner, last, run, nxt;
    logic [1:0]  cyc, stb, we;
    logic [15:0] adr [2];
    logic [15:0] wd [2];
    logic [15:0] rd;
    logic        ack;
    logic [54:0] exp_v, got_v;
    do_reset();
    owner = -1; last = 1; run = 0;
    cyc = '0; stb = '0; we = '0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(5) == 0) cyc[m] = ~cyc[m];
        stb[m] = cyc[m] & $urandom_range(1);
        we[m]  = $urandom_range(1);
        adr[m] = 16'($urandom);
        wd[m]  = 16'($urandom);
      end
      rd  = 16'($urandom);
      ack = $urandom_range(1);
      if (owner >= 0 && stb[owner] && run >= 4) ack = 1'b1;
      {m0_cyc, m1_cyc} = {cyc[0], cyc[1]};
      {m0_stb, m1_stb} = {stb[0], stb[1]};
      {m0_we, m1_we}   = {we[0], we[1]};
      m0_adr = adr[0]; m1_adr = adr[1]; m0_dat_i = wd[0]; m1_dat_i = wd[1];
      s_dat_i = rd; s_ack = ack;
      exp_v = {(owner == 1), (owner == 0),
               (owner >= 0) ? cyc[owner] : 1'b0,
               (owner >= 0) ? stb[owner] : 1'b0,
               (owner == 1) ? we[1] : we[0],
               (owner == 1) ? adr[1] : adr[0],
               (owner == 1) ? wd[1] : wd[0],
               ack && owner == 0, ack && owner == 1, 2'b00};
      #1;
      got_v = {gnt, s_cyc, s_stb, s_we, s_adr, s_dat_o, m0_ack, m1_ack, m0_err, m1_err};
      checks++;
      if (got_v !== exp_v || m0_dat_o !== rd || m1_dat_o !== rd) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h rd %h/%h, need %h rd %h",
                 c, got_v, m0_dat_o, m1_dat_o, exp_v, rd);
      end
      if (owner >= 0 && stb[owner] && !ack) run++;
      else run = 0;
      nxt = owner;
      if (owner < 0) begin
        if (cyc[0] && cyc[1]) nxt = (last == 0) ? 1 : 0;
        else if (cyc[0])      nxt = 0;
        else if (cyc[1])      nxt = 1;
      end else if (!cyc[owner]) begin
        last = owner;
        nxt  = cyc[1 - owner] ? 1 - owner : -1;
      end
      if (nxt != owner) run = 0;
      owner = nxt;
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_tie_handoff();
    test_fairness();
    test_ack_routing();
    test_lock();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
